// File: rtl/l0_buffer_status_controller.sv
// Tile sequencer for the L0 loading cycle counter: drives the weight/input/output buffer
// status codes, watches the returned load counts, then times compute and write-back per tile.
module l0_buffer_status_controller #(
    parameter int Nums_Pipeline_Stages                   = 4,
    parameter int L0_Weight_Nums                         = 2,
    parameter int L0_Input_Nums                          = 8,
    parameter int L0_Output_Nums                         = 8,
    parameter int Loading_From_Mem_Cycles_Start_Overhead = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [7:0]  Tile_Count,
    input  logic [10:0] Weight_Loading_From_Mem_Counter,
    input  logic [10:0] Input_Loading_From_Mem_Counter,
    input  logic [10:0] Output_Loading_From_Mem_Counter,
    output logic [1:0]  L0_Weight_Status,
    output logic [1:0]  L0_Input_Status,
    output logic [1:0]  L0_Output_Status,
    output logic        Counter_Clear,
    output logic        Compute_Active,
    output logic [4:0]  Compute_Step,
    output logic        Busy,
    output logic        Done
);

    localparam int Pipeline_Tail        = Nums_Pipeline_Stages - 1;
    localparam int Weight_Load_Cycles   = Loading_From_Mem_Cycles_Start_Overhead + L0_Weight_Nums;
    localparam int Input_Load_Cycles    = Loading_From_Mem_Cycles_Start_Overhead + L0_Input_Nums;
    localparam int Output_Load_Cycles   = Loading_From_Mem_Cycles_Start_Overhead + L0_Output_Nums;
    localparam int Output_Write_Cycles  = Loading_From_Mem_Cycles_Start_Overhead + L0_Output_Nums;
    localparam int L0_Computation_Steps = L0_Weight_Nums * L0_Output_Nums + Pipeline_Tail;

    localparam logic [10:0] WEIGHT_LAST = 11'(Weight_Load_Cycles - 1);
    localparam logic [10:0] INPUT_LAST  = 11'(Input_Load_Cycles - 1);
    localparam logic [10:0] OUTPUT_LAST = 11'(Output_Load_Cycles - 1);
    localparam logic [10:0] WRITE_LAST  = 11'(Output_Write_Cycles - 1);
    localparam logic [4:0]  STEP_LAST   = 5'(L0_Computation_Steps - 1);

    localparam logic [1:0] STATUS_EMPTY     = 2'b00;
    localparam logic [1:0] STATUS_LOADING   = 2'b01;
    localparam logic [1:0] STATUS_READY     = 2'b10;
    localparam logic [1:0] STATUS_WRITEBACK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_COMPUTE,
        S_WRITEBACK
    } state_t;

    state_t      state;
    logic [7:0]  tiles_left;
    logic [10:0] write_count;

    logic weight_hit;
    logic input_hit;
    logic output_hit;
    logic all_ready;

    // A load completes only on the exact terminal count while still loading;
    // overshooting counts are deliberately never treated as complete.
    assign weight_hit = (L0_Weight_Status == STATUS_LOADING) &&
                        (Weight_Loading_From_Mem_Counter == WEIGHT_LAST);
    assign input_hit  = (L0_Input_Status == STATUS_LOADING) &&
                        (Input_Loading_From_Mem_Counter == INPUT_LAST);
    assign output_hit = (L0_Output_Status == STATUS_LOADING) &&
                        (Output_Loading_From_Mem_Counter == OUTPUT_LAST);
    assign all_ready  = (L0_Weight_Status == STATUS_READY) &&
                        (L0_Input_Status == STATUS_READY) &&
                        (L0_Output_Status == STATUS_READY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            tiles_left       <= 8'd0;
            write_count      <= 11'd0;
            L0_Weight_Status <= STATUS_EMPTY;
            L0_Input_Status  <= STATUS_EMPTY;
            L0_Output_Status <= STATUS_EMPTY;
            Counter_Clear    <= 1'b0;
            Compute_Active   <= 1'b0;
            Compute_Step     <= 5'd0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
        end else begin
            Counter_Clear <= 1'b0;
            Done          <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (Tile_Count != 8'd0) begin
                            tiles_left    <= Tile_Count;
                            state         <= S_CLEAR;
                            Counter_Clear <= 1'b1;
                            Busy          <= 1'b1;
                        end else begin
                            Done <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    L0_Weight_Status <= STATUS_LOADING;
                    L0_Input_Status  <= STATUS_LOADING;
                    L0_Output_Status <= STATUS_LOADING;
                    state            <= S_LOAD;
                end

                S_LOAD: begin
                    if (weight_hit) L0_Weight_Status <= STATUS_READY;
                    if (input_hit)  L0_Input_Status  <= STATUS_READY;
                    if (output_hit) L0_Output_Status <= STATUS_READY;
                    if (all_ready) begin
                        state          <= S_COMPUTE;
                        Compute_Active <= 1'b1;
                        Compute_Step   <= 5'd0;
                    end
                end

                S_COMPUTE: begin
                    if (Compute_Step == STEP_LAST) begin
                        state            <= S_WRITEBACK;
                        Compute_Active   <= 1'b0;
                        Compute_Step     <= 5'd0;
                        L0_Weight_Status <= STATUS_EMPTY;
                        L0_Input_Status  <= STATUS_EMPTY;
                        L0_Output_Status <= STATUS_WRITEBACK;
                        write_count      <= 11'd0;
                    end else begin
                        Compute_Step <= Compute_Step + 5'd1;
                    end
                end

                // Write-back length is self-timed; the external output counter is not consulted here.
                S_WRITEBACK: begin
                    if (write_count == WRITE_LAST) begin
                        L0_Output_Status <= STATUS_EMPTY;
                        tiles_left       <= tiles_left - 8'd1;
                        if (tiles_left == 8'd1) begin
                            state <= S_IDLE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            state         <= S_CLEAR;
                            Counter_Clear <= 1'b1;
                        end
                    end else begin
                        write_count <= write_count + 11'd1;
                    end
                end

                default: begin
                    state            <= S_IDLE;
                    L0_Weight_Status <= STATUS_EMPTY;
                    L0_Input_Status  <= STATUS_EMPTY;
                    L0_Output_Status <= STATUS_EMPTY;
                    Compute_Active   <= 1'b0;
                    Compute_Step     <= 5'd0;
                    Busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l0_buffer_status_controller.sv
// Scoreboard bench: stimulus queues expected events/snapshots with hand-computed cycles,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_l0_buffer_status_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  Tile_Count = 8'd0;
    logic [10:0] w_cnt = 11'd0;
    logic [10:0] i_cnt = 11'd0;
    logic [10:0] o_cnt = 11'd0;
    logic [10:0] i_cnt_dut;
    logic        stall_input = 1'b0;
    logic [1:0]  L0_Weight_Status;
    logic [1:0]  L0_Input_Status;
    logic [1:0]  L0_Output_Status;
    logic        Counter_Clear;
    logic        Compute_Active;
    logic [4:0]  Compute_Step;
    logic        Busy;
    logic        Done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t0 = 0;
    int end_req = 0;
    int end_seen = 0;

    localparam int EV_CEND   = 0;
    localparam int EV_WBEND  = 1;
    localparam int EV_CLEAR  = 2;
    localparam int EV_WRDY   = 3;
    localparam int EV_IRDY   = 4;
    localparam int EV_ORDY   = 5;
    localparam int EV_CSTART = 6;
    localparam int EV_WB     = 7;
    localparam int EV_DONE   = 8;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    typedef struct {
        int          cyc;
        logic [15:0] vec;
    } snap_t;

    ev_t   ev_q[$];
    snap_t snap_q[$];

    assign i_cnt_dut = stall_input ? 11'd50 : i_cnt;

    l0_buffer_status_controller dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .Start                           (Start),
        .Tile_Count                      (Tile_Count),
        .Weight_Loading_From_Mem_Counter (w_cnt),
        .Input_Loading_From_Mem_Counter  (i_cnt_dut),
        .Output_Loading_From_Mem_Counter (o_cnt),
        .L0_Weight_Status                (L0_Weight_Status),
        .L0_Input_Status                 (L0_Input_Status),
        .L0_Output_Status                (L0_Output_Status),
        .Counter_Clear                   (Counter_Clear),
        .Compute_Active                  (Compute_Active),
        .Compute_Step                    (Compute_Step),
        .Busy                            (Busy),
        .Done                            (Done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural loading counter: cleared by Counter_Clear, counts while its status is LOADING.
    always @(posedge clk) begin
        if (!rst_n || Counter_Clear) begin
            w_cnt <= 11'd0;
            i_cnt <= 11'd0;
            o_cnt <= 11'd0;
        end else begin
            if (L0_Weight_Status == 2'b01) w_cnt <= w_cnt + 11'd1;
            if (L0_Input_Status == 2'b01)  i_cnt <= i_cnt + 11'd1;
            if (L0_Output_Status == 2'b01) o_cnt <= o_cnt + 11'd1;
        end
    end

    function automatic string ev_name(input int k);
        case (k)
            EV_CEND:   return "compute_end";
            EV_WBEND:  return "writeback_end";
            EV_CLEAR:  return "counter_clear";
            EV_WRDY:   return "weight_ready";
            EV_IRDY:   return "input_ready";
            EV_ORDY:   return "output_ready";
            EV_CSTART: return "compute_start";
            EV_WB:     return "writeback_start";
            EV_DONE:   return "done";
            default:   return "none";
        endcase
    endfunction

    task automatic exp_ev(input int kind, input int abs_cyc);
        ev_t e;
        e.kind = kind;
        e.cyc  = abs_cyc;
        ev_q.push_back(e);
    endtask

    task automatic exp_snap(input int abs_cyc, input logic [1:0] ws, input logic [1:0] is,
                            input logic [1:0] os, input logic busy, input logic cact,
                            input logic done, input logic clr, input logic [4:0] step);
        snap_t s;
        s.cyc = abs_cyc;
        s.vec = {ws, is, os, busy, cact, done, clr, step};
        snap_q.push_back(s);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic match_event(input int kind);
        ev_t e;
        if (ev_q.size() == 0) begin
            checkOutput({"unexpected ", ev_name(kind)}, kind, -1);
        end else begin
            e = ev_q.pop_front();
            checkOutput({"event kind want ", ev_name(e.kind)}, kind, e.kind);
            checkOutput({"event cycle ", ev_name(e.kind)}, cyc, e.cyc);
        end
    endtask

    logic [1:0] prev_ws = 2'b00;
    logic [1:0] prev_is = 2'b00;
    logic [1:0] prev_os = 2'b00;
    logic       prev_cact = 1'b0;

    always @(negedge clk) begin
        snap_t s;
        if (end_seen != end_req) begin
            checkOutput("pending events", ev_q.size(), 0);
            checkOutput("pending snapshots", snap_q.size(), 0);
            ev_q.delete();
            snap_q.delete();
            end_seen = end_req;
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            if (s.cyc < cyc)
                checkOutput("stale snapshot", s.cyc, cyc);
            else
                checkOutput($sformatf("snapshot@%0d", cyc),
                            int'({L0_Weight_Status, L0_Input_Status, L0_Output_Status, Busy,
                                  Compute_Active, Done, Counter_Clear, Compute_Step}),
                            int'(s.vec));
        end
        if (rst_n) begin
            if (prev_cact && !Compute_Active)                          match_event(EV_CEND);
            if (prev_os == 2'b11 && L0_Output_Status != 2'b11)         match_event(EV_WBEND);
            if (Counter_Clear)                                         match_event(EV_CLEAR);
            if (prev_ws != 2'b10 && L0_Weight_Status == 2'b10)         match_event(EV_WRDY);
            if (prev_is != 2'b10 && L0_Input_Status == 2'b10)          match_event(EV_IRDY);
            if (prev_os != 2'b10 && L0_Output_Status == 2'b10)         match_event(EV_ORDY);
            if (!prev_cact && Compute_Active)                          match_event(EV_CSTART);
            if (prev_os != 2'b11 && L0_Output_Status == 2'b11)         match_event(EV_WB);
            if (Done)                                                  match_event(EV_DONE);
        end
        prev_ws   = L0_Weight_Status;
        prev_is   = L0_Input_Status;
        prev_os   = L0_Output_Status;
        prev_cact = Compute_Active;
    end

    task automatic wait_until(input int abs_cyc);
        while (cyc < abs_cyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tc);
        Start      = 1'b1;
        Tile_Count = tc;
        @(posedge clk);
        #1;
        Start      = 1'b0;
        Tile_Count = 8'd0;
    endtask

    task automatic finish_phase(input int abs_cyc);
        wait_until(abs_cyc);
        end_req++;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_phase();
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        t0 = cyc;
        exp_snap(t0 + 1, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 5'd0);
        exp_snap(t0 + 2, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 5'd0);
        rst_n = 1'b1;
        finish_phase(t0 + 4);

        // Reset during LOAD of the first tile aborts without Done.
        begin_phase();
        exp_ev(EV_CLEAR, t0 + 1);
        exp_snap(t0 + 1, 2'd0, 2'd0, 2'd0, 1, 0, 0, 1, 5'd0);
        exp_snap(t0 + 40, 2'd1, 2'd1, 2'd1, 1, 0, 0, 0, 5'd0);
        for (int k = 51; k <= 55; k++)
            exp_snap(t0 + k, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 5'd0);
        applyStimulus(8'd2);
        wait_until(t0 + 50);
        rst_n = 1'b0;
        wait_until(t0 + 53);
        rst_n = 1'b1;
        finish_phase(t0 + 60);

        // Single tile with full timeline.
        begin_phase();
        exp_ev(EV_CLEAR, t0 + 1);
        exp_ev(EV_WRDY, t0 + 104);
        exp_ev(EV_IRDY, t0 + 110);
        exp_ev(EV_ORDY, t0 + 110);
        exp_ev(EV_CSTART, t0 + 111);
        exp_ev(EV_CEND, t0 + 130);
        exp_ev(EV_WB, t0 + 130);
        exp_ev(EV_WBEND, t0 + 238);
        exp_ev(EV_DONE, t0 + 238);
        exp_snap(t0 + 1, 2'd0, 2'd0, 2'd0, 1, 0, 0, 1, 5'd0);
        exp_snap(t0 + 2, 2'd1, 2'd1, 2'd1, 1, 0, 0, 0, 5'd0);
        exp_snap(t0 + 104, 2'd2, 2'd1, 2'd1, 1, 0, 0, 0, 5'd0);
        exp_snap(t0 + 110, 2'd2, 2'd2, 2'd2, 1, 0, 0, 0, 5'd0);
        exp_snap(t0 + 111, 2'd2, 2'd2, 2'd2, 1, 1, 0, 0, 5'd0);
        exp_snap(t0 + 129, 2'd2, 2'd2, 2'd2, 1, 1, 0, 0, 5'd18);
        exp_snap(t0 + 130, 2'd0, 2'd0, 2'd3, 1, 0, 0, 0, 5'd0);
        exp_snap(t0 + 237, 2'd0, 2'd0, 2'd3, 1, 0, 0, 0, 5'd0);
        exp_snap(t0 + 238, 2'd0, 2'd0, 2'd0, 0, 0, 1, 0, 5'd0);
        exp_snap(t0 + 239, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 5'd0);
        applyStimulus(8'd1);
        finish_phase(t0 + 242);

        // Three tiles; Start pulses in COMPUTE and WRITEBACK must be ignored.
        begin_phase();
        for (int k = 0; k < 3; k++) begin
            exp_ev(EV_CLEAR, t0 + 1 + 237 * k);
            exp_ev(EV_WRDY, t0 + 104 + 237 * k);
            exp_ev(EV_IRDY, t0 + 110 + 237 * k);
            exp_ev(EV_ORDY, t0 + 110 + 237 * k);
            exp_ev(EV_CSTART, t0 + 111 + 237 * k);
            exp_ev(EV_CEND, t0 + 130 + 237 * k);
            exp_ev(EV_WB, t0 + 130 + 237 * k);
            exp_ev(EV_WBEND, t0 + 238 + 237 * k);
        end
        exp_ev(EV_DONE, t0 + 712);
        exp_snap(t0 + 121, 2'd2, 2'd2, 2'd2, 1, 1, 0, 0, 5'd10);
        exp_snap(t0 + 201, 2'd0, 2'd0, 2'd3, 1, 0, 0, 0, 5'd0);
        exp_snap(t0 + 238, 2'd0, 2'd0, 2'd0, 1, 0, 0, 1, 5'd0);
        exp_snap(t0 + 712, 2'd0, 2'd0, 2'd0, 0, 0, 1, 0, 5'd0);
        applyStimulus(8'd3);
        wait_until(t0 + 120);
        applyStimulus(8'd5);
        wait_until(t0 + 200);
        applyStimulus(8'd5);
        finish_phase(t0 + 716);

        // Zero tiles: immediate Done, never busy.
        begin_phase();
        exp_ev(EV_DONE, t0 + 1);
        exp_snap(t0 + 1, 2'd0, 2'd0, 2'd0, 0, 0, 1, 0, 5'd0);
        exp_snap(t0 + 2, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 5'd0);
        applyStimulus(8'd0);
        finish_phase(t0 + 5);

        // Input counter stalled at 50: LOAD never completes.
        begin_phase();
        stall_input = 1'b1;
        exp_ev(EV_CLEAR, t0 + 1);
        exp_ev(EV_WRDY, t0 + 104);
        exp_ev(EV_ORDY, t0 + 110);
        exp_snap(t0 + 300, 2'd2, 2'd1, 2'd2, 1, 0, 0, 0, 5'd0);
        exp_snap(t0 + 302, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 5'd0);
        exp_snap(t0 + 304, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 5'd0);
        applyStimulus(8'd1);
        wait_until(t0 + 300);
        rst_n = 1'b0;
        wait_until(t0 + 302);
        rst_n = 1'b1;
        stall_input = 1'b0;
        finish_phase(t0 + 310);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l0_buffer_status_controller.md
Name: l0_buffer_status_controller

Overview:
- Tile-level sequencer that sits directly upstream of the L0 loading cycle counter.
- Generates the 2-bit L0_Weight/Input/Output_Status codes that drive that counter, and watches the counter values it returns to detect load completion.
- Once all three L0 buffers are loaded, it times the compute phase and the output write-back to memory, then repeats for the requested number of tiles.

Parameters:
- Nums_Pipeline_Stages, 4, MAC pipeline depth; Pipeline_Tail = Nums_Pipeline_Stages-1.
- L0_Weight_Nums, 2, weights per L0 tile.
- L0_Input_Nums, 8, inputs per L0 tile.
- L0_Output_Nums, 8, outputs per L0 tile.
- Loading_From_Mem_Cycles_Start_Overhead, 100, fixed memory access overhead in cycles.
- Weight_Load_Cycles, Overhead+L0_Weight_Nums (102), weight load length.
- Input_Load_Cycles, Overhead+L0_Input_Nums (108), input load length.
- Output_Load_Cycles, Overhead+L0_Output_Nums (108), output/partial-sum preload length.
- Output_Write_Cycles, Overhead+L0_Output_Nums (108), write-back length.
- L0_Computation_Steps, L0_Weight_Nums*L0_Output_Nums+Pipeline_Tail (19), compute cycles per tile.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- Start  in  1  one-cycle start request.
- Tile_Count  in  8  number of tiles; sampled on an accepted Start.
- Weight_Loading_From_Mem_Counter  in  11  from loading counter.
- Input_Loading_From_Mem_Counter  in  11  from loading counter.
- Output_Loading_From_Mem_Counter  in  11  from loading counter.
- L0_Weight_Status  out  2  weight buffer status to loading counter.
- L0_Input_Status  out  2  input buffer status to loading counter.
- L0_Output_Status  out  2  output buffer status to loading counter.
- Counter_Clear  out  1  one-cycle clear to the loading counters.
- Compute_Active  out  1  high during the compute phase.
- Compute_Step  out  5  current compute step, 0..L0_Computation_Steps-1.
- Busy  out  1  high whenever the FSM is not in IDLE.
- Done  out  1  one-cycle pulse at the end of the run.

Behaviour:
- Status encoding:
  - 00 IDLE/empty
  - 01 LOADING
  - 10 READY
  - 11 WRITEBACK (output buffer only; never driven on weight/input)
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE.
  - All status outputs = 00.
  - Counter_Clear, Compute_Active, Busy, Done = 0; Compute_Step = 0; tile counter = 0.
  - Reset mid-operation aborts immediately, with no Done pulse.
- All outputs are registered.
- FSM states: IDLE, CLEAR, LOAD, COMPUTE, WRITEBACK.
- IDLE:
  - Start=1 with Tile_Count!=0: latch Tile_Count into the remaining-tile counter and go to CLEAR.
  - Start=1 with Tile_Count==0: Done=1 on the next cycle; stay in IDLE.
  - Start is ignored in every other state.
- CLEAR (1 cycle):
  - Counter_Clear=1 and all statuses 00.
  - Next state LOAD.
- LOAD:
  - Entry: all three statuses = 01.
  - Each buffer independently: when its status is 01 and its counter input == its load cycles-1, that status becomes 10 on the next edge and holds.
  - When all three statuses are 10 in the same cycle, go to COMPUTE on the next edge.
  - Buffers finishing on the same cycle transition together.
- COMPUTE:
  - Compute_Active=1; Compute_Step counts 0..L0_Computation_Steps-1, one step per cycle.
  - All statuses hold 10.
  - After the last step: go to WRITEBACK; weight/input statuses become 00 and output status becomes 11.
- WRITEBACK:
  - Lasts exactly Output_Write_Cycles cycles, timed by an internal 11-bit counter; the external output counter is ignored.
  - At the end, output status becomes 00 and the remaining-tile count is decremented.
  - If tiles remain: go to CLEAR.
  - Otherwise: go to IDLE and assert Done for one cycle, coincident with the first IDLE cycle.
- Counter compare is exact equality; a counter value above the terminal value never completes the load.
- All internal counters are sized so they never wrap at maximum parameter values (11-bit cycle counter).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles during LOAD of tile 1 -> next cycle all statuses 00, Busy=0, Done stays 0; a later Start runs normally.
- Single tile, defaults, with a behavioural loading counter (counts while status=01, cleared by Counter_Clear), Start at cycle 0, Tile_Count=1 -> Counter_Clear at cycle 1; statuses 01 at cycle 2; weight 10 at cycle 104; input/output 10 at cycle 110; Compute_Active cycles 111-129 (Compute_Step 0..18); output status 11 for 108 cycles, cycles 130-237; Done at cycle 238.
- Tile_Count=3 -> exactly 3 CLEAR pulses, 3 compute windows of 19 cycles, one Done after the third write-back.
- Start asserted during COMPUTE and again during WRITEBACK -> ignored; tile count and timing unchanged.
- Start with Tile_Count=0 -> Done pulses the next cycle; Busy stays 0; statuses stay 00.
- Input counter held at 50 (stalled) -> FSM stays in LOAD indefinitely with input status 01, weight/output statuses 10, Compute_Active=0.
